// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O block behind the core's M stage: debounced keys and switches,
// key-press capture, display/LED registers and a millisecond countdown timer.
module mmio_ctrl #(
  parameter int DBITS    = 16,
  parameter int DBCYCLES = 500000,
  parameter int TICKDIV  = 50000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] WDATA,
  input  logic             WE,
  output logic [DBITS-1:0] RDATA,
  output logic             SEL,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [15:0]      HEX,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  localparam int DB_W = (DBCYCLES > 1) ? $clog2(DBCYCLES) : 1;
  localparam int TK_W = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

  logic [3:0]       key_s1_q, key_s2_q, key_smp_q, key_stable_q, key_edge_q;
  logic [3:0]       key_smp_d, key_stable_d, key_edge_d, key_fall;
  logic [9:0]       sw_s1_q, sw_s2_q, sw_smp_q, sw_stable_q;
  logic [9:0]       sw_smp_d, sw_stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [TK_W-1:0]  pre_q, pre_d;
  logic [DBITS-1:0] tcnt_q, tcnt_d;
  logic             en_q, en_d, exp_q, exp_d;
  logic [15:0]      hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;

  logic             wr, wr_edge, wr_tcnt, wr_hex, wr_ledr, wr_ledg, wr_ctl;
  logic             db_strobe, running, tick;
  logic [DBITS-1:0] rdata_c;

  assign SEL  = (ADDR[DBITS-1:4] == '1);
  assign wr   = WE && SEL;
  assign HEX  = hex_q;
  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

  // Register select ignores ADDR[0]; casez keeps the bit in the decode as don't-care.
  always_comb begin
    rdata_c = DBITS'(16'hDEAD);
    {wr_edge, wr_tcnt, wr_hex, wr_ledr, wr_ledg, wr_ctl} = '0;
    if (SEL) begin
      casez (ADDR[3:0])
        4'b000?: rdata_c = DBITS'({12'b0, key_stable_q});
        4'b001?: rdata_c = DBITS'({6'b0, sw_stable_q});
        4'b010?: begin rdata_c = DBITS'({12'b0, key_edge_q}); wr_edge = wr; end
        4'b011?: begin rdata_c = tcnt_q;                      wr_tcnt = wr; end
        4'b100?: begin rdata_c = DBITS'(hex_q);               wr_hex  = wr; end
        4'b101?: begin rdata_c = DBITS'({6'b0, ledr_q});      wr_ledr = wr; end
        4'b110?: begin rdata_c = DBITS'({8'b0, ledg_q});      wr_ledg = wr; end
        default: begin rdata_c = DBITS'({14'b0, en_q, exp_q}); wr_ctl = wr; end
      endcase
    end
  end

  assign RDATA = rdata_c;

  assign db_strobe = (db_cnt_q == DB_W'(DBCYCLES - 1));
  assign running   = en_q && (tcnt_q != '0);
  assign tick      = running && (pre_q == TK_W'(TICKDIV - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    db_cnt_d     = db_strobe ? '0 : db_cnt_q + 1'b1;
    key_smp_d    = key_smp_q;
    key_stable_d = key_stable_q;
    sw_smp_d     = sw_smp_q;
    sw_stable_d  = sw_stable_q;
    if (db_strobe) begin
      // A bit is accepted once two consecutive samples agree.
      key_smp_d    = key_s2_q;
      sw_smp_d     = sw_s2_q;
      key_stable_d = (~(key_s2_q ^ key_smp_q) & key_s2_q) | ((key_s2_q ^ key_smp_q) & key_stable_q);
      sw_stable_d  = (~(sw_s2_q ^ sw_smp_q) & sw_s2_q) | ((sw_s2_q ^ sw_smp_q) & sw_stable_q);
    end
    key_fall   = key_stable_q & ~key_stable_d;
    key_edge_d = (key_edge_q & ~(wr_edge ? WDATA[3:0] : 4'b0)) | key_fall;

    pre_d = pre_q;
    if (wr_tcnt)      pre_d = '0;
    else if (running) pre_d = tick ? '0 : pre_q + 1'b1;

    tcnt_d = tcnt_q;
    if (wr_tcnt)   tcnt_d = WDATA;
    else if (tick) tcnt_d = tcnt_q - 1'b1;

    exp_d = (exp_q & ~(wr_ctl & WDATA[0])) | (tick & (tcnt_q == DBITS'(1)) & ~wr_tcnt);
    en_d  = wr_ctl ? WDATA[1] : en_q;

    hex_d  = wr_hex  ? WDATA[15:0] : hex_q;
    ledr_d = wr_ledr ? WDATA[9:0]  : ledr_q;
    ledg_d = wr_ledg ? WDATA[7:0]  : ledg_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1_q     <= 4'hF;
      key_s2_q     <= 4'hF;
      key_smp_q    <= 4'hF;
      key_stable_q <= 4'hF;
      key_edge_q   <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      sw_smp_q     <= '0;
      sw_stable_q  <= '0;
      db_cnt_q     <= '0;
      pre_q        <= '0;
      tcnt_q       <= '0;
      en_q         <= 1'b0;
      exp_q        <= 1'b0;
      hex_q        <= '0;
      ledr_q       <= '0;
      ledg_q       <= '0;
    end else begin
      key_s1_q     <= KEY;
      key_s2_q     <= key_s1_q;
      key_smp_q    <= key_smp_d;
      key_stable_q <= key_stable_d;
      key_edge_q   <= key_edge_d;
      sw_s1_q      <= SW;
      sw_s2_q      <= sw_s1_q;
      sw_smp_q     <= sw_smp_d;
      sw_stable_q  <= sw_stable_d;
      db_cnt_q     <= db_cnt_d;
      pre_q        <= pre_d;
      tcnt_q       <= tcnt_d;
      en_q         <= en_d;
      exp_q        <= exp_d;
      hex_q        <= hex_d;
      ledr_q       <= ledr_d;
      ledg_q       <= ledg_d;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with short debounce/tick periods; expectations go
// through a scoreboard queue and are compared with immediate assertions.
module tb_mmio_ctrl;

  localparam int DBC = 4;
  localparam int TKD = 3;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] ADDR, WDATA, RDATA;
  logic        WE, SEL;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  mmio_ctrl #(.DBITS(16), .DBCYCLES(DBC), .TICKDIV(TKD)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .WDATA(WDATA), .WE(WE),
    .RDATA(RDATA), .SEL(SEL), .KEY(KEY), .SW(SW),
    .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
  );

  always #5 CLK = ~CLK;

  // Clock edges since the last reset release; edge k (k % DBC == 0) is a debounce strobe.
  int edge_k;
  always @(posedge CLK or negedge RESET_N)
    if (!RESET_N) edge_k <= 0;
    else          edge_k <= edge_k + 1;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected a queued value", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] v);
    expect_val(tag, v);
    check(obs);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] v, input string tag);
    expect_val(tag, v);
    ADDR = a;
    WE   = 1'b0;
    #1;
    check(RDATA);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR  = a;
    WDATA = d;
    WE    = 1'b1;
    @(posedge CLK);
    #1;
    WE = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bad, k0, s1, target, guard;
    RESET_N = 1'b0;
    ADDR = '0; WDATA = '0; WE = 1'b0; KEY = 4'hF; SW = '0;
    #12;
    chk("rst_hex", HEX, 16'h0);
    chk("rst_ledr", {6'b0, LEDR}, 16'h0);
    chk("rst_ledg", {8'b0, LEDG}, 16'h0);
    #10 RESET_N = 1'b1;
    cycles(1);

    // Reset-state register map
    rd(16'hFFF0, 16'h000F, "rd_fff0");
    rd(16'hFFF2, 16'h0000, "rd_fff2");
    rd(16'hFFF4, 16'h0000, "rd_fff4");
    rd(16'hFFF6, 16'h0000, "rd_fff6");
    rd(16'hFFF8, 16'h0000, "rd_fff8");
    rd(16'hFFFA, 16'h0000, "rd_fffa");
    rd(16'hFFFC, 16'h0000, "rd_fffc");
    cycles(1);
    rd(16'hFFFE, 16'h0000, "rd_fffe");
    rd(16'h1234, 16'hDEAD, "rd_1234");
    chk("sel_1234", {15'b0, SEL}, 16'h0);
    rd(16'hFFE0, 16'hDEAD, "rd_ffe0");
    chk("sel_ffe0", {15'b0, SEL}, 16'h0);
    rd(16'hFFF1, 16'h000F, "rd_fff1_alias");
    chk("sel_fff1", {15'b0, SEL}, 16'h1);

    // Key press: debounce latency and edge capture
    KEY = 4'b1110;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CLK); #1;
      ADDR = 16'hFFF0; #1;
      if (RDATA[0] === 1'b0 && lat < 0) lat = n;
    end
    chk("key_latency_ok", {15'b0, (lat >= 3 && lat <= 10)}, 16'h1);
    cycles(8);
    rd(16'hFFF0, 16'h000E, "key_stable_pressed");
    rd(16'hFFF4, 16'h0001, "key_edge_set");
    wr(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0000, "key_edge_w1c");
    KEY = 4'hF;
    cycles(20);
    rd(16'hFFF0, 16'h000F, "key_stable_released");
    rd(16'hFFF4, 16'h0000, "release_no_edge");

    // 3-cycle glitch must be filtered out
    KEY = 4'b1110;
    cycles(3);
    KEY = 4'hF;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLK); #1;
      ADDR = 16'hFFF0; #1;
      if (RDATA !== 16'h000F) bad++;
    end
    chk("glitch_filtered", bad[15:0], 16'h0);
    rd(16'hFFF4, 16'h0000, "glitch_no_edge");

    SW = 10'h2A5;
    cycles(20);
    rd(16'hFFF2, 16'h02A5, "sw_stable");

    // Output registers
    wr(16'hFFF8, 16'hBEEF);
    wr(16'hFFFA, 16'hFFFF);
    wr(16'hFFFC, 16'hFFFF);
    chk("hex_port", HEX, 16'hBEEF);
    chk("ledr_port", {6'b0, LEDR}, 16'h03FF);
    chk("ledg_port", {8'b0, LEDG}, 16'h00FF);
    rd(16'hFFF8, 16'hBEEF, "rd_hex");
    rd(16'hFFFA, 16'h03FF, "rd_ledr");
    rd(16'hFFFC, 16'h00FF, "rd_ledg");

    // Timer countdown and expiry
    wr(16'hFFF6, 16'h0002);
    wr(16'hFFFE, 16'h0002);
    cycles(2);
    rd(16'hFFF6, 16'h0002, "tcnt_before_tick");
    cycles(1);
    rd(16'hFFF6, 16'h0001, "tcnt_after_3");
    cycles(3);
    rd(16'hFFF6, 16'h0000, "tcnt_after_6");
    rd(16'hFFFE, 16'h0003, "exp_set");
    cycles(5);
    rd(16'hFFF6, 16'h0000, "tcnt_no_wrap");
    wr(16'hFFFE, 16'h0003);
    rd(16'hFFFE, 16'h0002, "exp_cleared");

    // Load coincident with a tick: load wins, no decrement
    wr(16'hFFF6, 16'h0005);
    cycles(2);
    wr(16'hFFF6, 16'h0007);
    rd(16'hFFF6, 16'h0007, "load_beats_tick");
    cycles(2);
    rd(16'hFFF6, 16'h0007, "tcnt_hold_after_load");
    cycles(1);
    rd(16'hFFF6, 16'h0006, "tcnt_next_tick");

    wr(16'hFFF6, 16'h0000);
    rd(16'hFFFE, 16'h0002, "load_zero_no_exp");

    // Expiry coincident with an EXP clear: expiry wins
    wr(16'hFFF6, 16'h0001);
    cycles(2);
    wr(16'hFFFE, 16'h0003);
    rd(16'hFFFE, 16'h0003, "expiry_beats_clear");
    rd(16'hFFF6, 16'h0000, "tcnt_expired");

    // Asynchronous reset mid-countdown
    wr(16'hFFF6, 16'h0009);
    cycles(2);
    #2 RESET_N = 1'b0;
    rd(16'hFFF6, 16'h0000, "async_rst_tcnt");
    rd(16'hFFFE, 16'h0000, "async_rst_ctl");
    chk("async_rst_hex", HEX, 16'h0);
    chk("async_rst_ledr", {6'b0, LEDR}, 16'h0);
    #1 RESET_N = 1'b1;

    // Key edge landing on the same edge as a write-1-clear of that bit
    cycles(1);
    KEY = 4'b1110;
    k0 = edge_k;
    s1 = ((k0 + 3 + DBC - 1) / DBC) * DBC;
    target = s1 + DBC - 1;
    guard = 0;
    while (edge_k < target && guard < 40) begin
      cycles(1);
      guard++;
    end
    chk("edge_align_reached", edge_k[15:0], target[15:0]);
    wr(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0001, "edge_set_beats_clear");
    rd(16'hFFF0, 16'h000E, "edge_stable_pressed");
    wr(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0000, "edge_cleared_after");

    chk("scoreboard_drained", sb_q.size(), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
